wb_arbiter: RTL and testbench

Writeback arbiter directly upstream of the 16×16 register bank. It merges two result sources into the bank's single write port: ALU results (every cycle, no backpressure) and memory-load results (valid/ready). It decodes the 4-bit destination into the bank's one-hot 16-bit write-enable vector and drives the 16-bit write-data bus. Load results are buffered in a small FIFO while the ALU owns the port.

---
 rtl/wb_arbiter_pkg.sv | 13 +
 rtl/wb_load_fifo.sv | 62 ++++++
 rtl/wb_arbiter.sv | 79 +++++++
 tb/tb_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - register bank geometry and the dest to one-hot decode
package wb_arbiter_pkg;
  localparam int REG_COUNT = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;

  function automatic logic [REG_COUNT-1:0] dest_onehot(input logic [REG_IDX_W-1:0] dest);
    logic [REG_COUNT-1:0] v;
    v       = '0;
    v[dest] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - circular load buffer with per-entry squash by destination
module wb_load_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_IDX_W-1:0]  push_dest,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [REG_IDX_W-1:0]  squash_dest,
  output logic                  full,
  output logic                  empty,
  output logic                  head_valid,
  output logic [REG_IDX_W-1:0]  head_dest,
  output logic [DATA_W-1:0]     head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                 ent_valid [DEPTH];
  logic [REG_IDX_W-1:0] ent_dest  [DEPTH];
  logic [DATA_W-1:0]    ent_data  [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign head_valid = ent_valid[head];
  assign head_dest  = ent_dest[head];
  assign head_data  = ent_data[head];

  // Squash is applied before the push so a same-cycle load stays live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_valid[i] <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && ent_dest[i] == squash_dest) ent_valid[i] <= 1'b0;
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_dest[tail] <= push_dest;
      ent_data[tail] <= push_data;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and load results onto the register bank write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LOAD_DEPTH  = 2,
  parameter bit R0_READONLY = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [REG_IDX_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        mem_valid,
  input  logic [REG_IDX_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        mem_ready,
  output logic [DATA_W-1:0]           wb_bus,
  output logic [REG_COUNT-1:0]        reg_enable,
  output logic [$clog2(LOAD_DEPTH):0] load_pending
);
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 head_valid;
  logic [REG_IDX_W-1:0] head_dest;
  logic [DATA_W-1:0]    head_data;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_dest;
  logic [DATA_W-1:0]    wr_data;
  logic                 discard;

  assign mem_ready = !full;
  assign push      = mem_valid && !full;
  assign pop       = !alu_valid && !empty;

  wb_load_fifo #(.DEPTH(LOAD_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_dest   (mem_dest),
    .push_data   (mem_data),
    .pop         (pop),
    .squash      (alu_valid),
    .squash_dest (alu_dest),
    .full        (full),
    .empty       (empty),
    .head_valid  (head_valid),
    .head_dest   (head_dest),
    .head_data   (head_data),
    .count       (load_pending)
  );

  // A squashed head still pops but produces no write.
  always_comb begin
    wr_en   = 1'b0;
    wr_dest = alu_dest;
    wr_data = alu_data;
    if (alu_valid) begin
      wr_en = 1'b1;
    end else if (pop) begin
      wr_en   = head_valid;
      wr_dest = head_dest;
      wr_data = head_data;
    end
  end

  assign discard = R0_READONLY && (wr_dest == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_enable <= '0;
      wb_bus     <= '0;
    end else begin
      reg_enable <= (wr_en && !discard) ? dest_onehot(wr_dest) : '0;
      if (wr_en) wb_bus <= wr_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed checks of wb_arbiter against a queue model
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [15:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready0, mem_ready1;
  logic [15:0] wb_bus0, wb_bus1, reg_enable0, reg_enable1;
  logic [1:0]  load_pending0, load_pending1;

  always #5 clk = ~clk;

  wb_arbiter #(.LOAD_DEPTH(DEPTH), .R0_READONLY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready0),
    .wb_bus(wb_bus0), .reg_enable(reg_enable0), .load_pending(load_pending0));

  wb_arbiter #(.LOAD_DEPTH(DEPTH), .R0_READONLY(1'b1)) dut1 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready1),
    .wb_bus(wb_bus1), .reg_enable(reg_enable1), .load_pending(load_pending1));

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] data;
    bit          live;
  } ent_t;

  int checks = 0;
  int errors = 0;
  ent_t q[$];
  logic [15:0] m_bus = '0;
  logic [15:0] exp_en0, exp_en1, exp_bus;
  logic        exp_ready;
  int          exp_pend;
  logic [15:0] obs_en0, obs_en1, obs_bus0, obs_bus1;
  logic        obs_ready0, obs_ready1;
  int          obs_pend0, obs_pend1;
  bit          accepted;

  // One clock of stimulus; the model works on whole queue entries, not pointers.
  task automatic drive_cycle(input bit av, input logic [3:0] ad, input logic [15:0] ax,
                             input bit mv, input logic [3:0] md, input logic [15:0] mx);
    ent_t e;
    alu_valid = av; alu_dest = ad; alu_data = ax;
    mem_valid = mv; mem_dest = md; mem_data = mx;
    #1;
    obs_ready0 = mem_ready0; obs_ready1 = mem_ready1;
    obs_pend0 = int'(load_pending0); obs_pend1 = int'(load_pending1);
    exp_ready = (q.size() < DEPTH);
    exp_pend  = q.size();
    exp_en0 = '0; exp_en1 = '0; exp_bus = m_bus;
    if (av) begin
      exp_en0 = 16'(1) << ad;
      exp_en1 = (ad == 4'd0) ? 16'h0 : exp_en0;
      exp_bus = ax;
      foreach (q[i]) if (q[i].dest == ad) q[i].live = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.live) begin
        exp_en0 = 16'(1) << e.dest;
        exp_en1 = (e.dest == 4'd0) ? 16'h0 : exp_en0;
        exp_bus = e.data;
      end
    end
    accepted = mv && exp_ready;
    if (accepted) q.push_back('{md, mx, 1'b1});
    m_bus = exp_bus;
    @(posedge clk);
    #1;
    obs_en0 = reg_enable0; obs_en1 = reg_enable1;
    obs_bus0 = wb_bus0; obs_bus1 = wb_bus1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (reg_enable0 !== 16'h0 || wb_bus0 !== 16'h0 || load_pending0 !== 2'd0 || mem_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: en=%h bus=%h pend=%0d ready=%b want 0000/0000/0/1",
               reg_enable0, wb_bus0, load_pending0, mem_ready0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_alu_only();
    drive_cycle(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0);
    checks++;
    if (obs_en0 !== 16'h0020 || obs_bus0 !== 16'hBEEF || obs_en1 !== 16'h0020) begin
      errors++;
      $display("FAIL alu_only: en=%h/%h bus=%h want 0020/0020 beef", obs_en0, obs_en1, obs_bus0);
    end
    drive_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    checks++;
    if (obs_en0 !== 16'h0 || obs_bus0 !== 16'hBEEF) begin
      errors++;
      $display("FAIL alu_release: en=%h bus=%h want 0000 beef", obs_en0, obs_bus0);
    end
  endtask

  task automatic test_load_idle();
    drive_cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234);
    checks++;
    if (obs_en0 !== 16'h0 || load_pending0 !== 2'd1) begin
      errors++;
      $display("FAIL load_accept: en=%h pend=%0d want 0000 1", obs_en0, load_pending0);
    end
    drive_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    checks++;
    if (obs_en0 !== 16'h0008 || obs_bus0 !== 16'h1234 || load_pending0 !== 2'd0) begin
      errors++;
      $display("FAIL load_write: en=%h bus=%h pend=%0d want 0008 1234 0", obs_en0, obs_bus0, load_pending0);
    end
  endtask

  task automatic test_contention();
    int k;
    logic [15:0] ld [3];
    ld[0] = 16'hA001; ld[1] = 16'hA002; ld[2] = 16'hA003;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c < 4, 4'(c + 12), 16'(16'hC000 + c), k < 3, 4'(k + 8), ld[k % 3]);
      if (accepted) k++;
      checks++;
      if (obs_en0 !== exp_en0 || obs_en1 !== exp_en1 || obs_bus0 !== exp_bus
          || obs_ready0 !== exp_ready || obs_pend0 !== exp_pend) begin
        errors++;
        $display("FAIL contention c%0d: en=%h bus=%h rdy=%b pend=%0d want %h %h %b %0d",
                 c, obs_en0, obs_bus0, obs_ready0, obs_pend0, exp_en0, exp_bus, exp_ready, exp_pend);
      end
      if (c == 2) begin
        checks++;
        if (obs_ready0 !== 1'b0) begin
          errors++;
          $display("FAIL contention_full: ready=%b want 0", obs_ready0);
        end
      end
    end
    checks++;
    if (k != 3 || load_pending0 !== 2'd0) begin
      errors++;
      $display("FAIL contention_drain: accepted=%0d pend=%0d want 3 0", k, load_pending0);
    end
  endtask

  task automatic test_squash();
    int r7_hits, r2_hits;
    r7_hits = 0; r2_hits = 0;
    drive_cycle(1'b1, 4'd1, 16'h0101, 1'b1, 4'd7, 16'h1111);
    drive_cycle(1'b1, 4'd1, 16'h0102, 1'b1, 4'd2, 16'h2222);
    drive_cycle(1'b1, 4'd7, 16'hAAAA, 1'b0, 4'd0, 16'h0);
    checks++;
    if (obs_en0 !== 16'h0080 || obs_bus0 !== 16'hAAAA) begin
      errors++;
      $display("FAIL squash_alu: en=%h bus=%h want 0080 aaaa", obs_en0, obs_bus0);
    end
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      if (obs_en0 === 16'h0080) r7_hits++;
      if (obs_en0 === 16'h0004 && obs_bus0 === 16'h2222) r2_hits++;
      checks++;
      if (obs_en0 !== exp_en0 || obs_bus0 !== exp_bus) begin
        errors++;
        $display("FAIL squash_drain c%0d: en=%h bus=%h want %h %h", c, obs_en0, obs_bus0, exp_en0, exp_bus);
      end
    end
    checks++;
    if (r7_hits != 0 || r2_hits != 1) begin
      errors++;
      $display("FAIL squash_count: r7 writes=%0d r2 writes=%0d want 0 1", r7_hits, r2_hits);
    end
  endtask

  task automatic test_same_cycle();
    drive_cycle(1'b1, 4'd4, 16'h4444, 1'b1, 4'd4, 16'h5555);
    checks++;
    if (obs_en0 !== 16'h0010 || obs_bus0 !== 16'h4444) begin
      errors++;
      $display("FAIL same_cycle_alu: en=%h bus=%h want 0010 4444", obs_en0, obs_bus0);
    end
    drive_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    checks++;
    if (obs_en0 !== 16'h0010 || obs_bus0 !== 16'h5555) begin
      errors++;
      $display("FAIL same_cycle_load: en=%h bus=%h want 0010 5555", obs_en0, obs_bus0);
    end
  endtask

  task automatic test_r0();
    drive_cycle(1'b1, 4'd0, 16'h0F0F, 1'b1, 4'd0, 16'hF0F0);
    drive_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    checks++;
    if (obs_en0 !== 16'h0001 || obs_en1 !== 16'h0000 || obs_bus0 !== 16'hF0F0) begin
      errors++;
      $display("FAIL r0_load: en0=%h en1=%h bus=%h want 0001 0000 f0f0", obs_en0, obs_en1, obs_bus0);
    end
  endtask

  task automatic test_reset_mid_drain(input logic [3:0] d);
    int bad;
    bad = 0;
    drive_cycle(1'b1, 4'd9, 16'h9999, 1'b1, d, 16'h7001);
    drive_cycle(1'b1, 4'd9, 16'h9998, 1'b1, d, 16'h7002);
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if (reg_enable0 !== 16'h0 || reg_enable1 !== 16'h0 || wb_bus0 !== 16'h0
        || load_pending0 !== 2'd0 || mem_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_drain d%0d: en=%h/%h bus=%h pend=%0d ready=%b want 0 0 0 0 1",
               d, reg_enable0, reg_enable1, wb_bus0, load_pending0, mem_ready0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    m_bus = '0;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      if (obs_en0 !== 16'h0 || obs_en1 !== 16'h0 || obs_bus0 !== 16'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_stale d%0d: %0d cycles wrote after reset, want 0", d, bad);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_cycle($urandom_range(0, 9) < 4, 4'($urandom_range(0, 3)), 16'($urandom),
                  $urandom_range(0, 9) < 6, 4'($urandom_range(0, 3)), 16'($urandom));
      checks++;
      if (obs_en0 !== exp_en0 || obs_en1 !== exp_en1 || obs_bus0 !== exp_bus || obs_bus1 !== exp_bus
          || obs_ready0 !== exp_ready || obs_ready1 !== exp_ready
          || obs_pend0 !== exp_pend || obs_pend1 !== exp_pend) begin
        errors++;
        $display("FAIL random c%0d: en=%h/%h bus=%h rdy=%b pend=%0d want %h/%h %h %b %0d",
                 c, obs_en0, obs_en1, obs_bus0, obs_ready0, obs_pend0,
                 exp_en0, exp_en1, exp_bus, exp_ready, exp_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_load_idle();
    test_contention();
    test_squash();
    test_same_cycle();
    test_r0();
    test_reset_mid_drain(4'd6);
    test_reset_mid_drain(4'd0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
